// File: rtl/rlwe_vec_lsu.sv
// Vector load/store burst sequencer between the RLWE datapath and the RLWE dmem router port.
// Optional: define RLWE_LSU_WINDOW_CHK_EN to reject bursts that cross a 64 KiB router window.
module rlwe_vec_lsu #(
    parameter int unsigned LANE          = 8,
    parameter int unsigned LEN_W         = 12,
    parameter int unsigned RD_FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_cmd_valid,
    output logic                 o_cmd_ready,
    input  logic                 i_cmd_write,
    input  logic [31:0]          i_cmd_addr,
    input  logic [LEN_W-1:0]     i_cmd_len,
    input  logic                 i_wr_valid,
    output logic                 o_wr_ready,
    input  logic [LANE*32-1:0]   i_wr_data,
    output logic                 o_rd_valid,
    input  logic                 i_rd_ready,
    output logic [LANE*32-1:0]   o_rd_data,
    output logic                 o_done,
    output logic                 o_err,
    output logic                 o_dmem_req,
    input  logic                 i_dmem_req_ack,
    output logic                 o_dmem_cmd,
    output logic [1:0]           o_dmem_width,
    output logic [31:0]          o_dmem_addr,
    output logic [LANE*32-1:0]   o_dmem_wdata,
    input  logic [LANE*32-1:0]   i_dmem_rdata,
    input  logic [1:0]           i_dmem_resp
);

    localparam int unsigned DW     = LANE * 32;
    localparam logic [31:0] STRIDE = 32'(LANE * 4);
    localparam int unsigned PTR_W  = $clog2(RD_FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned CRD_W  = CNT_W + 1;

    // SCR1 memory-interface encodings: cmd RD=0/WR=1, width WORD=2'b10, resp RDY_OK/RDY_ER.
    localparam logic [1:0] WIDTH_WORD = 2'b10;
    localparam logic [1:0] RESP_OK    = 2'b01;
    localparam logic [1:0] RESP_ER    = 2'b10;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StFin} state_e;

    state_e             r_state;
    state_e             w_state_d;
    logic [31:0]        r_addr;
    logic [31:0]        w_addr_d;
    logic [LEN_W-1:0]   r_remaining;
    logic [LEN_W-1:0]   w_remaining_d;
    logic               r_write;
    logic               w_write_d;
    logic               r_err;
    logic               w_err_d;
    logic               r_outstanding;
    logic               w_outstanding_d;

    logic [DW-1:0]      r_mem [RD_FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [CNT_W-1:0]   r_count;

    logic               w_resp_ok;
    logic               w_resp_er;
    logic               w_fifo_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_credit_ok;
    logic               w_slot_free;
    logic               w_issue_ok;
    logic               w_accept;
    logic               w_window_cross;

    assign w_resp_ok    = r_outstanding && (i_dmem_resp == RESP_OK);
    assign w_resp_er    = r_outstanding && (i_dmem_resp == RESP_ER);
    assign w_fifo_empty = (r_count == '0);
    assign w_push       = w_resp_ok && !r_write;
    assign w_pop        = o_rd_valid && i_rd_ready;

    // Every in-flight load owns a FIFO slot; a pop this cycle frees one early.
    assign w_credit_ok  = (CRD_W'(r_count) + CRD_W'(r_outstanding))
                          < (CRD_W'(RD_FIFO_DEPTH) + CRD_W'(w_pop));
    assign w_slot_free  = !r_outstanding || w_resp_ok;
    assign w_issue_ok   = (r_state == StIssue) && w_slot_free
                          && (r_write ? i_wr_valid : w_credit_ok);
    assign w_accept     = w_issue_ok && i_dmem_req_ack;

    assign o_dmem_req   = w_issue_ok;
    assign o_wr_ready   = w_accept && r_write;
    assign o_dmem_cmd   = r_write;
    assign o_dmem_width = WIDTH_WORD;
    assign o_dmem_addr  = r_addr;
    assign o_dmem_wdata = ((r_state == StIssue) && r_write) ? i_wr_data : '0;

`ifdef RLWE_LSU_WINDOW_CHK_EN
    logic [31:0] w_last_addr;
    assign w_last_addr    = i_cmd_addr + (32'(i_cmd_len) * STRIDE) - 32'd1;
    assign w_window_cross = (i_cmd_len != '0) && (i_cmd_addr[31:16] != w_last_addr[31:16]);
`else
    assign w_window_cross = 1'b0;
`endif

    always_comb begin
        w_state_d       = r_state;
        w_addr_d        = r_addr;
        w_remaining_d   = r_remaining;
        w_write_d       = r_write;
        w_err_d         = r_err;
        w_outstanding_d = r_outstanding;
        o_cmd_ready     = 1'b0;
        o_done          = 1'b0;
        o_err           = 1'b0;

        if (w_resp_ok || w_resp_er) begin
            w_outstanding_d = 1'b0;
        end
        if (w_accept) begin
            w_outstanding_d = 1'b1;
        end

        unique case (r_state)
            StIdle: begin
                // Hold off new bursts until the datapath has drained earlier load data.
                o_cmd_ready = w_fifo_empty;
                if (i_cmd_valid && w_fifo_empty) begin
                    w_addr_d      = i_cmd_addr;
                    w_remaining_d = i_cmd_len;
                    w_write_d     = i_cmd_write;
                    w_err_d       = w_window_cross;
                    if ((i_cmd_len == '0) || w_window_cross) begin
                        w_state_d = StFin;
                    end else begin
                        w_state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                if (w_resp_er) begin
                    w_err_d   = 1'b1;
                    w_state_d = StFin;
                end else if (w_accept) begin
                    w_addr_d      = r_addr + STRIDE;
                    w_remaining_d = r_remaining - LEN_W'(1);
                    if (r_remaining == LEN_W'(1)) begin
                        w_state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (w_resp_er) begin
                    w_err_d   = 1'b1;
                    w_state_d = StFin;
                end else if (w_resp_ok) begin
                    w_state_d = StFin;
                end
            end
            StFin: begin
                o_done    = 1'b1;
                o_err     = r_err;
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= StIdle;
            r_addr        <= '0;
            r_remaining   <= '0;
            r_write       <= 1'b0;
            r_err         <= 1'b0;
            r_outstanding <= 1'b0;
        end else begin
            r_state       <= w_state_d;
            r_addr        <= w_addr_d;
            r_remaining   <= w_remaining_d;
            r_write       <= w_write_d;
            r_err         <= w_err_d;
            r_outstanding <= w_outstanding_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_dmem_rdata;
        end
    end

    assign o_rd_valid = !w_fifo_empty;
    assign o_rd_data  = w_fifo_empty ? '0 : r_mem[r_rptr];

    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(w_push && (r_count == CNT_W'(RD_FIFO_DEPTH))))
        else $fatal(1, "rlwe_vec_lsu: read FIFO push while full");

endmodule
